// File: rtl/core_bpu.sv
// Branch prediction unit: direct-mapped BTB, gshare-indexed 2-bit counters and a
// speculative return stack, with one-cycle registered prediction and miss repair.
module core_bpu #(
    parameter int  BTB_ENTRIES = 64,
    parameter int  RAS_DEPTH   = 8,
    parameter int  HIST_W      = 5,
    localparam int IDX_W       = $clog2(BTB_ENTRIES),
    localparam int PTR_W       = $clog2(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              stall_i,
    input  logic [31:0]       pc_i,
    output logic              resp_valid_o,
    output logic [31:0]       predict_pc_o,
    output logic              taken_o,
    output logic              dir_type_o,
    output logic [1:0]        target_type_o,
    output logic [1:0]        lphr_o,
    output logic [HIST_W-1:0] history_o,
    output logic [PTR_W-1:0]  ras_ptr_o,
    input  logic              cor_valid_i,
    input  logic              cor_miss_i,
    input  logic [31:0]       cor_pc_i,
    input  logic              cor_true_taken_i,
    input  logic [31:0]       cor_true_target_i,
    input  logic [1:0]        cor_lphr_i,
    input  logic [HIST_W-1:0] cor_history_i,
    input  logic              cor_true_dir_i,
    input  logic [1:0]        cor_true_target_type_i,
    input  logic [PTR_W-1:0]  cor_ras_ptr_i
);
    localparam int TAG_W = 30 - IDX_W;

    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
    logic [31:0]            r_btb_target [BTB_ENTRIES];
    logic                   r_btb_dir    [BTB_ENTRIES];
    logic [1:0]             r_btb_tt     [BTB_ENTRIES];
    logic [1:0]             r_cnt        [BTB_ENTRIES];
    logic [31:0]            r_ras        [RAS_DEPTH];
    logic [HIST_W-1:0]      r_ghr;
    logic [PTR_W-1:0]       r_ras_ptr;

    logic              r_resp_valid, r_taken, r_dir;
    logic [31:0]       r_predict_pc;
    logic [1:0]        r_tt, r_lphr;
    logic [HIST_W-1:0] r_history;
    logic [PTR_W-1:0]  r_ptr_out;

    // Lookup path: all reads are combinational from current state, so the
    // registered response naturally sees the table before this edge's writes.
    logic [IDX_W-1:0] w_idx, w_cidx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit, w_dir, w_taken, w_accept, w_repair;
    logic [1:0]       w_tt, w_cnt;
    logic [31:0]      w_pc_plus4, w_predict;

    assign w_idx      = pc_i[IDX_W+1:2];
    assign w_tag      = pc_i[31:IDX_W+2];
    assign w_cidx     = w_idx ^ IDX_W'(r_ghr);
    assign w_hit      = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
    assign w_dir      = w_hit ? r_btb_dir[w_idx] : 1'b0;
    assign w_tt       = w_hit ? r_btb_tt[w_idx] : 2'd0;
    assign w_cnt      = r_cnt[w_cidx];
    assign w_taken    = w_hit && (!w_dir || w_cnt[1]);
    assign w_pc_plus4 = pc_i + 32'd4;
    assign w_predict  = !w_taken ? w_pc_plus4 :
                        (w_tt == 2'd2) ? r_ras[r_ras_ptr - PTR_W'(1)] : r_btb_target[w_idx];
    assign w_accept   = req_valid_i && !stall_i;
    assign w_repair   = cor_valid_i && cor_miss_i;

    // Correction path
    logic [IDX_W-1:0] w_cor_idx, w_cnt_widx;
    logic [TAG_W-1:0] w_cor_tag;
    logic             w_btb_we, w_cnt_we;
    logic [1:0]       w_cnt_wdata;

    assign w_cor_idx  = cor_pc_i[IDX_W+1:2];
    assign w_cor_tag  = cor_pc_i[31:IDX_W+2];
    assign w_cnt_widx = w_cor_idx ^ IDX_W'(cor_history_i);
    assign w_cnt_we   = cor_valid_i && cor_true_dir_i;
    assign w_btb_we   = cor_valid_i && (cor_true_taken_i ||
                        (r_btb_valid[w_cor_idx] && r_btb_tag[w_cor_idx] == w_cor_tag));

    always_comb begin
        w_cnt_wdata = cor_lphr_i;
        if (cor_true_taken_i && cor_lphr_i != 2'd3)
            w_cnt_wdata = cor_lphr_i + 2'd1;
        else if (!cor_true_taken_i && cor_lphr_i != 2'd0)
            w_cnt_wdata = cor_lphr_i - 2'd1;
    end

    // Speculative history/RAS next state; a repair replaces it wholesale.
    logic [HIST_W-1:0] w_ghr_next;
    logic [PTR_W-1:0]  w_ptr_next, w_ras_waddr;
    logic [31:0]       w_ras_wdata;
    logic              w_ras_we;

    always_comb begin
        w_ghr_next  = r_ghr;
        w_ptr_next  = r_ras_ptr;
        w_ras_we    = 1'b0;
        w_ras_waddr = r_ras_ptr;
        w_ras_wdata = w_pc_plus4;
        if (w_repair) begin
            w_ghr_next = cor_true_dir_i ? {cor_history_i[HIST_W-2:0], cor_true_taken_i}
                                        : cor_history_i;
            w_ptr_next = cor_ras_ptr_i;
            if (cor_true_taken_i && cor_true_target_type_i == 2'd1) begin
                w_ras_we    = 1'b1;
                w_ras_waddr = cor_ras_ptr_i;
                w_ras_wdata = cor_pc_i + 32'd4;
                w_ptr_next  = cor_ras_ptr_i + PTR_W'(1);
            end else if (cor_true_taken_i && cor_true_target_type_i == 2'd2) begin
                w_ptr_next = cor_ras_ptr_i - PTR_W'(1);
            end
        end else if (w_accept) begin
            if (w_taken && w_tt == 2'd1) begin
                w_ras_we   = 1'b1;
                w_ptr_next = r_ras_ptr + PTR_W'(1);
            end else if (w_taken && w_tt == 2'd2) begin
                w_ptr_next = r_ras_ptr - PTR_W'(1);
            end
            if (w_hit && w_dir)
                w_ghr_next = {r_ghr[HIST_W-2:0], w_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) r_cnt[i] <= 2'b01;
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= 32'd0;
            r_ghr     <= '0;
            r_ras_ptr <= '0;
        end else begin
            if (w_btb_we) r_btb_valid[w_cor_idx] <= 1'b1;
            if (w_cnt_we) r_cnt[w_cnt_widx] <= w_cnt_wdata;
            if (w_ras_we) r_ras[w_ras_waddr] <= w_ras_wdata;
            r_ghr     <= w_ghr_next;
            r_ras_ptr <= w_ptr_next;
        end
    end

    // Payload fields are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_btb_we) begin
            r_btb_tag[w_cor_idx]    <= w_cor_tag;
            r_btb_target[w_cor_idx] <= cor_true_target_i;
            r_btb_dir[w_cor_idx]    <= cor_true_dir_i;
            r_btb_tt[w_cor_idx]     <= cor_true_target_type_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_predict_pc <= 32'd0;
            r_taken      <= 1'b0;
            r_dir        <= 1'b0;
            r_tt         <= 2'd0;
            r_lphr       <= 2'd0;
            r_history    <= '0;
            r_ptr_out    <= '0;
        end else if (!stall_i) begin
            r_resp_valid <= w_accept && !w_repair;
            if (w_accept) begin
                r_predict_pc <= w_predict;
                r_taken      <= w_taken;
                r_dir        <= w_dir;
                r_tt         <= w_tt;
                r_lphr       <= w_cnt;
                r_history    <= r_ghr;
                r_ptr_out    <= r_ras_ptr;
            end
        end
    end

    assign resp_valid_o  = r_resp_valid;
    assign predict_pc_o  = r_predict_pc;
    assign taken_o       = r_taken;
    assign dir_type_o    = r_dir;
    assign target_type_o = r_tt;
    assign lphr_o        = r_lphr;
    assign history_o     = r_history;
    assign ras_ptr_o     = r_ptr_out;
endmodule

// File: tb/tb_core_bpu.sv
// Directed bench for core_bpu: training, calls/returns, RAS wrap, miss repair, stall and reset.
module tb_core_bpu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, stall_i;
    logic [31:0] pc_i;
    logic        resp_valid_o, taken_o, dir_type_o;
    logic [31:0] predict_pc_o;
    logic [1:0]  target_type_o, lphr_o;
    logic [4:0]  history_o;
    logic [2:0]  ras_ptr_o;
    logic        cor_valid_i, cor_miss_i, cor_true_taken_i, cor_true_dir_i;
    logic [31:0] cor_pc_i, cor_true_target_i;
    logic [1:0]  cor_lphr_i, cor_true_target_type_i;
    logic [4:0]  cor_history_i;
    logic [2:0]  cor_ras_ptr_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_bpu dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .stall_i(stall_i), .pc_i(pc_i),
        .resp_valid_o(resp_valid_o), .predict_pc_o(predict_pc_o), .taken_o(taken_o),
        .dir_type_o(dir_type_o), .target_type_o(target_type_o), .lphr_o(lphr_o),
        .history_o(history_o), .ras_ptr_o(ras_ptr_o),
        .cor_valid_i(cor_valid_i), .cor_miss_i(cor_miss_i), .cor_pc_i(cor_pc_i),
        .cor_true_taken_i(cor_true_taken_i), .cor_true_target_i(cor_true_target_i),
        .cor_lphr_i(cor_lphr_i), .cor_history_i(cor_history_i),
        .cor_true_dir_i(cor_true_dir_i), .cor_true_target_type_i(cor_true_target_type_i),
        .cor_ras_ptr_i(cor_ras_ptr_i)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic lookup(input logic [31:0] pc);
        req_valid_i = 1'b1;
        pc_i        = pc;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic set_cor(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                           input logic dir, input logic [1:0] tt, input logic [1:0] lphr,
                           input logic [4:0] hist, input logic miss, input logic [2:0] ptr);
        cor_valid_i = 1'b1; cor_pc_i = pc; cor_true_target_i = tgt; cor_true_taken_i = taken;
        cor_true_dir_i = dir; cor_true_target_type_i = tt; cor_lphr_i = lphr;
        cor_history_i = hist; cor_miss_i = miss; cor_ras_ptr_i = ptr;
    endtask

    task automatic correct(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                           input logic dir, input logic [1:0] tt, input logic [1:0] lphr,
                           input logic [4:0] hist);
        set_cor(pc, tgt, taken, dir, tt, lphr, hist, 1'b0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        cor_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid_i = 1'b0; stall_i = 1'b0; pc_i = '0;
        cor_valid_i = 1'b0; cor_miss_i = 1'b0; cor_pc_i = '0; cor_true_taken_i = 1'b0;
        cor_true_target_i = '0; cor_lphr_i = '0; cor_history_i = '0; cor_true_dir_i = 1'b0;
        cor_true_target_type_i = '0; cor_ras_ptr_i = '0;
        #1;
        check_value("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check_value("rst_predict_pc", predict_pc_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // cold lookup: miss, counter at reset value
        lookup(32'h1000);
        check_value("cold_resp_valid", 32'(resp_valid_o), 32'd1);
        check_value("cold_taken", 32'(taken_o), 32'd0);
        check_value("cold_predict_pc", predict_pc_o, 32'h1004);
        check_value("cold_lphr", 32'(lphr_o), 32'd1);
        check_value("cold_target_type", 32'(target_type_o), 32'd0);

        // train conditional branch, then it predicts taken with counter 2
        correct(32'h1000, 32'h2000, 1'b1, 1'b1, 2'd3, 2'd1, 5'd0);
        lookup(32'h1000);
        check_value("cond_taken", 32'(taken_o), 32'd1);
        check_value("cond_predict_pc", predict_pc_o, 32'h2000);
        check_value("cond_lphr", 32'(lphr_o), 32'd2);
        check_value("cond_dir_type", 32'(dir_type_o), 32'd1);

        // stall holds outputs; idle cycle drops valid
        stall_i = 1'b1; req_valid_i = 1'b1; pc_i = 32'h5010;
        @(posedge clk); @(negedge clk);
        check_value("stall_predict_pc", predict_pc_o, 32'h2000);
        check_value("stall_resp_valid", 32'(resp_valid_o), 32'd1);
        stall_i = 1'b0; req_valid_i = 1'b0;
        @(posedge clk); @(negedge clk);
        check_value("idle_resp_valid", 32'(resp_valid_o), 32'd0);

        // calls and return
        correct(32'h3000, 32'h5000, 1'b1, 1'b0, 2'd1, 2'd1, 5'd0);
        correct(32'h3104, 32'h5000, 1'b1, 1'b0, 2'd1, 2'd1, 5'd0);
        correct(32'h5010, 32'h0, 1'b1, 1'b0, 2'd2, 2'd1, 5'd0);
        lookup(32'h3000);
        check_value("call_predict_pc", predict_pc_o, 32'h5000);
        check_value("call_ras_ptr", 32'(ras_ptr_o), 32'd0);
        lookup(32'h5010);
        check_value("ret_predict_pc", predict_pc_o, 32'h3004);
        check_value("ret_ras_ptr", 32'(ras_ptr_o), 32'd1);

        // nine back-to-back calls wrap the 8-entry stack
        for (int i = 0; i < 8; i++) begin
            lookup(32'h3000);
            check_value($sformatf("wrap_call%0d_ptr", i), 32'(ras_ptr_o), 32'(i));
        end
        lookup(32'h3104);
        check_value("wrap_call8_ptr", 32'(ras_ptr_o), 32'd0);
        lookup(32'h5010);
        check_value("wrap_ret_ptr", 32'(ras_ptr_o), 32'd1);
        check_value("wrap_ret_predict_pc", predict_pc_o, 32'h3108);

        // mispredict repair together with a lookup of a call
        set_cor(32'h7008, 32'h9000, 1'b1, 1'b1, 2'd3, 2'd1, 5'b00101, 1'b1, 3'd3);
        req_valid_i = 1'b1; pc_i = 32'h3000;
        @(posedge clk); @(negedge clk);
        cor_valid_i = 1'b0; cor_miss_i = 1'b0; req_valid_i = 1'b0;
        check_value("miss_resp_valid", 32'(resp_valid_o), 32'd0);
        lookup(32'h8010);
        check_value("repair_history", 32'(history_o), 32'h0B);
        check_value("repair_ras_ptr", 32'(ras_ptr_o), 32'd3);
        check_value("repair_predict_pc", predict_pc_o, 32'h8014);

        // asynchronous reset mid-stream
        lookup(32'h3104);
        check_value("pre_rst_resp_valid", 32'(resp_valid_o), 32'd1);
        check_value("pre_rst_predict_pc", predict_pc_o, 32'h5000);
        #2 rst = 1'b1;
        #1;
        check_value("async_rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check_value("async_rst_predict_pc", predict_pc_o, 32'd0);
        check_value("async_rst_taken", 32'(taken_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lookup(32'h3104);
        check_value("post_rst_taken", 32'(taken_o), 32'd0);
        check_value("post_rst_predict_pc", predict_pc_o, 32'h3108);
        check_value("post_rst_resp_valid", 32'(resp_valid_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/core_bpu.md
Name: core_bpu

Overview:
- Branch prediction unit feeding the fetch stage.
- On each fetch request it produces a one-cycle-latency prediction bundle: predict_pc, taken, dir_type, target_type, lphr, history and ras_ptr.
- It consumes the correction bundle returned by the execute-stage branch resolver. Corrections update the BTB and the 2-bit direction counters, and repair the speculative global history and return-address stack on a mispredict.

Parameters:
BTB_ENTRIES, 64, direct-mapped BTB size (power of 2); IDX_W = log2(BTB_ENTRIES)
RAS_DEPTH, 8, return stack entries (power of 2); PTR_W = log2(RAS_DEPTH)
HIST_W, 5, global history bits (HIST_W <= IDX_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid_i  in  1  fetch lookup request
stall_i  in  1  hold the response registers
pc_i  in  32  fetch PC (word aligned)
resp_valid_o  out  1  prediction valid
predict_pc_o  out  32  predicted next PC
taken_o  out  1  predicted taken
dir_type_o  out  1  1 = conditional, 0 = unconditional
target_type_o  out  2  0 none, 1 call, 2 return, 3 immediate
lphr_o  out  2  counter value used for this prediction
history_o  out  HIST_W  global history used for this prediction
ras_ptr_o  out  PTR_W  RAS pointer before this prediction's push/pop
cor_valid_i  in  1  correction valid
cor_miss_i  in  1  mispredict, repair speculative state
cor_pc_i  in  32  branch PC
cor_true_taken_i  in  1  resolved direction
cor_true_target_i  in  32  resolved target
cor_lphr_i  in  2  lphr echoed from the prediction
cor_history_i  in  HIST_W  history echoed from the prediction
cor_true_dir_i  in  1  resolved dir_type
cor_true_target_type_i  in  2  resolved target_type
cor_ras_ptr_i  in  PTR_W  ras_ptr echoed from the prediction

Behaviour:
- Reset (async, rst=1):
  - All BTB valid bits = 0; all counters = 2'b01.
  - ghr = 0, ras_ptr = 0, RAS contents = 0.
  - All outputs = 0.
- Index fields:
  - BTB index = pc[IDX_W+1:2]; BTB tag = pc[31:IDX_W+2].
  - Counter index = pc[IDX_W+1:2] XOR zero-extended ghr.
- Lookup:
  - When req_valid_i && !stall_i at edge N, the outputs at N+1 reflect table state before any edge-N write (read-before-write).
  - If req_valid_i = 0 and stall_i = 0, resp_valid_o = 0 at N+1.
  - If stall_i = 1, all outputs hold and no speculative state changes.
- Prediction:
  - hit = valid && tag match.
  - taken = hit && (dir_type == 0 || counter[1]).
  - predict_pc = pc + 4 if not taken; RAS[ras_ptr-1] if target_type == 2; otherwise the BTB target.
  - On a miss: dir_type = 0, target_type = 0.
  - lphr_o = counter; history_o = ghr before update.
- Speculative update on an accepted lookup:
  - Taken call (target_type 1): RAS[ras_ptr] = pc + 4, then ras_ptr + 1.
  - Taken return (target_type 2): ras_ptr - 1.
  - Hit on a conditional: ghr = {ghr[HIST_W-2:0], taken}.
  - ras_ptr wraps modulo RAS_DEPTH. Overflow overwrites the oldest entry; underflow wraps silently.
- Correction (cor_valid_i):
  - Counter write at pc index XOR cor_history_i, only when cor_true_dir_i = 1. Value = cor_lphr_i saturating +1 if taken, -1 if not taken (saturates at 3 and 0).
  - BTB write when cor_true_taken_i || existing tag hit. Fields written: valid = 1, tag, target = cor_true_target_i, dir_type = cor_true_dir_i, target_type = cor_true_target_type_i.
- Miss repair (cor_valid_i && cor_miss_i):
  - ghr = cor_true_dir_i ? {cor_history_i[HIST_W-2:0], cor_true_taken_i} : cor_history_i.
  - ras_ptr = cor_ras_ptr_i, then:
    - If the resolved branch is a taken call: push cor_pc_i + 4.
    - If it is a taken return: decrement.
  - The repair overrides any same-cycle speculative update.
  - resp_valid_o = 0 at the next edge regardless of req_valid_i, because fetch is being redirected.
- Simultaneous events: a correction write and a lookup to the same index in the same cycle returns the old entry; the new entry is visible from the following lookup.
- Reset mid-operation clears all state immediately, including a pending response.

Test Plan:
- Reset, then lookup pc 0x1000 -> resp_valid_o = 1, taken_o = 0, predict_pc_o = 0x1004, lphr_o = 1, target_type_o = 0.
- Correction {pc 0x1000, taken, target 0x2000, dir 1, type 3, lphr 1, hist 0}, then lookup 0x1000 -> taken_o = 1, predict_pc_o = 0x2000, lphr_o = 2.
- Train call 0x3000 -> 0x5000 (type 1, dir 0) and return 0x5010 (type 2, dir 0):
  - Lookup 0x3000 -> predict_pc_o = 0x5000, ras_ptr_o = 0.
  - Lookup 0x5010 -> predict_pc_o = 0x3004, ras_ptr_o = 1.
- Nine consecutive predicted calls with RAS_DEPTH = 8 -> ras_ptr wraps to 1; the next return predicts the ninth call's pc + 4.
- Mispredict correction {miss 1, ras_ptr 3, history 5'b00101, dir 1, taken 1} together with req_valid_i -> resp_valid_o = 0 next cycle; the following lookup shows history_o = 5'b01011, ras_ptr_o = 3.
- Assert rst mid-stream with resp_valid_o = 1 -> all outputs 0 immediately; a lookup of any previously trained PC predicts not-taken, pc + 4.
